// File: rtl/fpu_pkg.sv
// Shared FPU operand-unpack definitions: class bit indices, special exponents, FSM states.
// Used by fpu_classify and fpu_unpack.
package fpu_pkg;

  localparam int CLASS_ZERO = 0;
  localparam int CLASS_SUB  = 1;
  localparam int CLASS_NORM = 2;
  localparam int CLASS_INF  = 3;
  localparam int CLASS_SNAN = 4;
  localparam int CLASS_QNAN = 5;

  localparam logic signed [9:0] EXP_ZERO    = -10'sd150;
  localparam logic signed [9:0] EXP_SPECIAL = 10'sd128;
  localparam logic signed [9:0] BIAS        = 10'sd127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational binary32 decode to one-hot class, initial exponent and significand (sign not needed).
// FPU_UNPACK_FAST_NORM_EN: subnormals leave fully normalized; otherwise pre-shifted by one place.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [30:0]        mag,
  output logic [5:0]         cls,
  output logic signed [9:0]  exp,
  output logic [23:0]        sig
);

  logic [7:0]  e;
  logic [22:0] f;

  assign e = mag[30:23];
  assign f = mag[22:0];

`ifdef FPU_UNPACK_FAST_NORM_EN
  logic [23:0] fz;
  logic [4:0]  lz;
  logic        found;

  assign fz = {1'b0, f};

  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && fz[i]) begin
        lz    = 5'(23 - i);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    cls = '0;
    exp = EXP_ZERO;
    sig = '0;
    if (e == 8'd0) begin
      if (f == 23'd0) begin
        cls[CLASS_ZERO] = 1'b1;
      end else begin
        cls[CLASS_SUB] = 1'b1;
`ifdef FPU_UNPACK_FAST_NORM_EN
        sig = fz << lz;
        exp = -10'sd126 - $signed({5'd0, lz});
`else
        // First normalizing shift is folded into the accept edge.
        sig = {f, 1'b0};
        exp = -10'sd127;
`endif
      end
    end else if (e == 8'hFF) begin
      exp = EXP_SPECIAL;
      sig = {1'b1, f};
      if (f == 23'd0)  cls[CLASS_INF]  = 1'b1;
      else if (f[22])  cls[CLASS_QNAN] = 1'b1;
      else             cls[CLASS_SNAN] = 1'b1;
    end else begin
      cls[CLASS_NORM] = 1'b1;
      exp = $signed({2'b00, e}) - BIAS;
      sig = {1'b1, f};
    end
  end

endmodule

// File: rtl/fpu_unpack.sv
// Operand-unpack stage: registers sign/exp/sig/class of two binary32 operands; one pair in flight.
// Latency: accept edge for non-subnormals, max(s1,s2)-1 more edges for subnormals (accept-edge always with FPU_UNPACK_FAST_NORM_EN); input stalls while normalizing or while result is held.
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             rs1_i,
  input  logic [31:0]             rs2_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             rs1_o,
  output logic [31:0]             rs2_o,
  output logic signed [9:0]       rs1Exp_o,
  output logic signed [9:0]       rs2Exp_o,
  output logic [23:0]             rs1Sig_o,
  output logic [23:0]             rs2Sig_o,
  output logic [5:0]              rs1Class_o,
  output logic [5:0]              rs2Class_o,
  output logic [TAG_W-1:0]        tag_o
);

  state_t state_q, state_d;
  logic   out_valid_d;
  logic   accept;
  logic   init_done;

  logic [5:0]        cls1, cls2;
  logic signed [9:0] exp1, exp2;
  logic [23:0]       sig1, sig2;

  fpu_classify u_cls1 (.mag(rs1_i[30:0]), .cls(cls1), .exp(exp1), .sig(sig1));
  fpu_classify u_cls2 (.mag(rs2_i[30:0]), .cls(cls2), .exp(exp2), .sig(sig2));

`ifdef FPU_UNPACK_FAST_NORM_EN
  assign init_done = 1'b1;
`else
  logic        sh1, sh2;
  logic [23:0] nsig1, nsig2;
  logic        norm_done;

  assign init_done = (~cls1[CLASS_SUB] | sig1[23]) & (~cls2[CLASS_SUB] | sig2[23]);

  assign sh1   = rs1Class_o[CLASS_SUB] & ~rs1Sig_o[23];
  assign sh2   = rs2Class_o[CLASS_SUB] & ~rs2Sig_o[23];
  assign nsig1 = sh1 ? {rs1Sig_o[22:0], 1'b0} : rs1Sig_o;
  assign nsig2 = sh2 ? {rs2Sig_o[22:0], 1'b0} : rs2Sig_o;
  assign norm_done = (~rs1Class_o[CLASS_SUB] | nsig1[23]) &
                     (~rs2Class_o[CLASS_SUB] | nsig2[23]);
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_o;
    in_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_o = 1'b1;
      ST_FULL: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`ifndef FPU_UNPACK_FAST_NORM_EN
      ST_NORM: begin
        if (norm_done) begin
          out_valid_d = 1'b1;
          state_d     = ST_FULL;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid_i & in_ready_o;
    if (accept) begin
      out_valid_d = init_done;
      state_d     = init_done ? ST_FULL : ST_NORM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      out_valid_o <= 1'b0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rs1Exp_o    <= '0;
      rs2Exp_o    <= '0;
      rs1Sig_o    <= '0;
      rs2Sig_o    <= '0;
      rs1Class_o  <= '0;
      rs2Class_o  <= '0;
      tag_o       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_o <= out_valid_d;
      if (accept) begin
        rs1_o      <= rs1_i;
        rs2_o      <= rs2_i;
        tag_o      <= tag_i;
        rs1Class_o <= cls1;
        rs2Class_o <= cls2;
        rs1Exp_o   <= exp1;
        rs2Exp_o   <= exp2;
        rs1Sig_o   <= sig1;
        rs2Sig_o   <= sig2;
      end
`ifndef FPU_UNPACK_FAST_NORM_EN
      else if (state_q == ST_NORM) begin
        rs1Sig_o <= nsig1;
        rs2Sig_o <= nsig2;
        if (sh1) rs1Exp_o <= rs1Exp_o - 10'sd1;
        if (sh2) rs2Exp_o <= rs2Exp_o - 10'sd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fpu_unpack.sv
// Directed bench for fpu_unpack (default iterative-normalization build).
module tb_fpu_unpack;

  localparam int TAG_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       rs1_i, rs2_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       rs1_o, rs2_o;
  logic signed [9:0] rs1Exp_o, rs2Exp_o;
  logic [23:0]       rs1Sig_o, rs2Sig_o;
  logic [5:0]        rs1Class_o, rs2Class_o;
  logic [TAG_W-1:0]  tag_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  fpu_unpack #(.TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs1Exp_o(rs1Exp_o), .rs2Exp_o(rs2Exp_o),
    .rs1Sig_o(rs1Sig_o), .rs2Sig_o(rs2Sig_o),
    .rs1Class_o(rs1Class_o), .rs2Class_o(rs2Class_o),
    .tag_o(tag_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] e10(input int v);
    logic [9:0] t;
    t = v[9:0];
    return {22'd0, t};
  endfunction

  function automatic logic [31:0] ex(input logic signed [9:0] v);
    return {22'd0, v};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int  n;
    logic stall_ok;
    logic stale;

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    rs1_i = '0; rs2_i = '0; tag_i = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_rs1_o", rs1_o, 32'd0);
    chk("rst_rs1_exp", ex(rs1Exp_o), 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    rst_ni = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Test 1: two normals
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; rs1_i = 32'h3F80_0000; rs2_i = 32'hC000_0000; tag_i = 5'd3;
    step();
    in_valid_i = 1'b0;
    chk("t1_valid", 32'(out_valid_o), 32'd1);
    chk("t1_rs1_class", 32'(rs1Class_o), 32'h04);
    chk("t1_rs1_exp", ex(rs1Exp_o), e10(0));
    chk("t1_rs1_sig", 32'(rs1Sig_o), 32'h80_0000);
    chk("t1_rs2_exp", ex(rs2Exp_o), e10(1));
    chk("t1_rs2_sig", 32'(rs2Sig_o), 32'h80_0000);
    chk("t1_rs2_o", rs2_o, 32'hC000_0000);
    chk("t1_tag", 32'(tag_o), 32'd3);
    chk("t1_in_ready", 32'(in_ready_o), 32'd1);
    step();

    // Test 2: worst-case subnormal plus one-shift subnormal
    in_valid_i = 1'b1; rs1_i = 32'h0000_0001; rs2_i = 32'h0040_0000; tag_i = 5'd7;
    step();
    in_valid_i = 1'b0;
    n = 0; stall_ok = 1'b1;
    while (!out_valid_o && n < 40) begin
      if (in_ready_o !== 1'b0) stall_ok = 1'b0;
      n++;
      step();
    end
    chk("t2_stall_cycles", n, 32'd22);
    chk("t2_in_ready_low", 32'(stall_ok), 32'd1);
    chk("t2_rs1_exp", ex(rs1Exp_o), e10(-149));
    chk("t2_rs1_sig", 32'(rs1Sig_o), 32'h80_0000);
    chk("t2_rs1_class", 32'(rs1Class_o), 32'h02);
    chk("t2_rs2_exp", ex(rs2Exp_o), e10(-127));
    chk("t2_rs2_sig", 32'(rs2Sig_o), 32'h80_0000);
    chk("t2_rs2_class", 32'(rs2Class_o), 32'h02);

    // Test 3: zero and infinity, accepted straight from FULL
    in_valid_i = 1'b1; rs1_i = 32'h0000_0000; rs2_i = 32'h7F80_0000; tag_i = 5'd1;
    step();
    in_valid_i = 1'b0;
    chk("t3_valid", 32'(out_valid_o), 32'd1);
    chk("t3_rs1_class", 32'(rs1Class_o), 32'h01);
    chk("t3_rs1_exp", ex(rs1Exp_o), e10(-150));
    chk("t3_rs1_sig", 32'(rs1Sig_o), 32'd0);
    chk("t3_rs2_class", 32'(rs2Class_o), 32'h08);
    chk("t3_rs2_exp", ex(rs2Exp_o), e10(128));
    chk("t3_rs2_sig", 32'(rs2Sig_o), 32'h80_0000);

    // Test 4: signalling and quiet NaN
    in_valid_i = 1'b1; rs1_i = 32'h7F80_0001; rs2_i = 32'h7FC0_0000; tag_i = 5'd2;
    step();
    in_valid_i = 1'b0;
    chk("t4_rs1_class", 32'(rs1Class_o), 32'h10);
    chk("t4_rs2_class", 32'(rs2Class_o), 32'h20);
    chk("t4_rs1_exp", ex(rs1Exp_o), e10(128));
    chk("t4_rs2_exp", ex(rs2Exp_o), e10(128));
    chk("t4_rs1_sig", 32'(rs1Sig_o), 32'h80_0001);
    chk("t4_rs2_sig", 32'(rs2Sig_o), 32'hC0_0000);

    // Test 5: hold result under backpressure, then bubble-free accept
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; rs1_i = 32'h4049_0FDB; rs2_i = 32'hBF00_0000; tag_i = 5'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", 32'(out_valid_o), 32'd1);
      chk("t5_hold_rs1", rs1_o, 32'h7F80_0001);
      chk("t5_hold_class", 32'(rs1Class_o), 32'h10);
      chk("t5_hold_tag", 32'(tag_o), 32'd2);
      chk("t5_in_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    #1;
    chk("t5_bypass_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    chk("t5_new_valid", 32'(out_valid_o), 32'd1);
    chk("t5_new_rs1", rs1_o, 32'h4049_0FDB);
    chk("t5_new_rs1_exp", ex(rs1Exp_o), e10(1));
    chk("t5_new_rs1_sig", 32'(rs1Sig_o), 32'hC9_0FDB);
    chk("t5_new_rs2_exp", ex(rs2Exp_o), e10(-1));
    chk("t5_new_tag", 32'(tag_o), 32'd9);

    // Subnormal needing only one shift: accept-edge latency
    in_valid_i = 1'b1; rs1_i = 32'h0040_0000; rs2_i = 32'h3F80_0000; tag_i = 5'd4;
    step();
    in_valid_i = 1'b0;
    chk("t7_valid", 32'(out_valid_o), 32'd1);
    chk("t7_rs1_exp", ex(rs1Exp_o), e10(-127));
    chk("t7_rs1_class", 32'(rs1Class_o), 32'h02);
    step();

    // Test 6: reset during normalization
    in_valid_i = 1'b1; rs1_i = 32'h0000_0001; rs2_i = 32'h3F80_0000; tag_i = 5'd5;
    step();
    in_valid_i = 1'b0;
    step(); step(); step();
    chk("t6_in_norm_ready", 32'(in_ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid_o), 32'd0);
    chk("t6_rst_rs1", rs1_o, 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    chk("t6_ready_after", 32'(in_ready_o), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid_o !== 1'b0) stale = 1'b1;
      step();
    end
    chk("t6_no_stale", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
